iord_addr_unit: RTL and testbench
=================================

Name: iord_addr_unit

Overview:
- Parametrised, registered successor to the 2-input IorD memory-address selector of the multicycle datapath.
- Selects one of NSRC address sources (PC, AluOut, exception vector, …), latches it, checks alignment against access size, then runs a memory-access sequence with a configurable wait-state count.
- Sits between the datapath registers and the memory address/write ports and reports done or error back to the control unit.

Parameters:
- WIDTH, 32, address/source width in bits.
- NSRC, 4, number of address sources; SEL_W = max(1, clog2(NSRC)) is a derived localparam.
- MEM_LAT, 1, memory wait cycles, 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request an access; sampled only when busy=0.
- sel  in  SEL_W  source index; 0=PC, 1=AluOut by convention.
- src_flat  in  NSRC*WIDTH  concatenated sources; source i occupies bits [i*WIDTH +: WIDTH].
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- write  in  1  1=store, 0=load; latched with start.
- addr  out  WIDTH  registered memory address.
- mem_wr  out  1  memory write strobe.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  one-cycle alignment-error pulse.
- bad_sel  out  1  one-cycle invalid-select pulse.

Behaviour:
- Reset, including mid-access: state IDLE, counter 0, addr=0; mem_wr, busy, done, misalign and bad_sel all 0. Any in-flight access is abandoned with no done pulse.
- States: IDLE, WAIT, DONE, ERR. Start is accepted in IDLE, DONE or ERR (busy=0), so back-to-back accesses are legal. Start while busy=1 is ignored.
- Accept at edge E0:
  - addr <= src[sel], or 0 if sel >= NSRC.
  - size and write are latched.
  - Alignment fault: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 always.
- Invalid sel (sel >= NSRC) -> ERR. bad_sel=1 for one cycle after E0, misalign=0, addr=0, no memory access.
- Misalignment with valid sel -> ERR. misalign=1 for one cycle after E0; addr holds the faulting address for EPC/BadVAddr capture; busy=0, mem_wr=0.
- Valid access -> WAIT with counter=MEM_LAT; busy=1 from after E0.
  - Counter decrements each edge.
  - At the edge where counter==0: go to DONE, busy=0, done=1 for exactly one cycle.
  - Result: done is high in the cycle after edge E0+MEM_LAT+1. With MEM_LAT=0, done follows E0+1.
- mem_wr = busy AND latched write; never asserted in ERR or DONE.
- addr is stable from E0 until the next accepted start. It is never changed by sel/src edits while busy.
- DONE/ERR with no start -> IDLE at the next edge; outputs keep their values except the pulses, which clear.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package cpu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum {IDLE, WAIT, DONE, ERR}.
  - source index constants SRC_PC=0, SRC_ALUOUT=1.
- One sub-module addr_align_check: combinational, inputs addr[1:0] and size, output fault. It is reused later by the load/store byte-enable logic.

Test Plan:
- Reset mid-WAIT (MEM_LAT=3, write=1, reset asserted 1 cycle after start) -> next cycle busy=0, mem_wr=0, addr=0; no done pulse ever.
- PC word load: sel=0, PC=0x0000_0040, size=10, write=0, MEM_LAT=1 -> addr=0x40 after E0; busy high 2 cycles; done pulse at E0+2; mem_wr=0 throughout.
- AluOut halfword store: sel=1, AluOut=0x1000_0006, size=01, write=1, MEM_LAT=2 -> mem_wr=1 for 3 cycles; done at E0+3; addr=0x1000_0006.
- Misaligned word: sel=1, AluOut=0x0000_0102, size=10 -> misalign=1 for one cycle after E0, addr=0x102, busy=0, mem_wr=0, done=0.
- Invalid select with NSRC=3: sel=3 -> bad_sel=1 pulse, addr=0, no busy. Also size=11 with valid sel -> misalign=1.
- Back-to-back: start held high across DONE, MEM_LAT=0 -> second access accepted in the DONE cycle; two done pulses 2 cycles apart. Toggling sel while busy leaves addr unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath encodings: access sizes, memory-address unit states and source indices.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int SRC_PC     = 0;
  localparam int SRC_ALUOUT = 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

endpackage

// File: rtl/addr_align_check.sv
// Combinational alignment check of an address against an access size; size 11 is reserved and always faults.
module addr_align_check
  import cpu_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] size,
  output logic       fault
);

  always_comb begin
    fault = 1'b0;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = a[0];
      SZ_WORD: fault = |a;
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/iord_addr_unit.sv
// Registered IorD address selector: picks a source, checks alignment and runs a wait-stated memory access.
module iord_addr_unit
  import cpu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NSRC    = 4,
  parameter  int MEM_LAT = 1,
  localparam int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [1:0]            size,
  input  logic                  write,
  output logic [WIDTH-1:0]      addr,
  output logic                  mem_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign,
  output logic                  bad_sel
);

  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic             wr_q;
  logic [WIDTH-1:0] src_sel;
  logic             sel_ok, fault, accept;

  // Out-of-range selects fall through to zero, which keeps the fault check quiet.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < NSRC; i++)
      if (sel == SEL_W'(i)) src_sel = src_flat[i*WIDTH +: WIDTH];
  end

  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(NSRC));

  addr_align_check u_align (
    .a     (src_sel[1:0]),
    .size  (size),
    .fault (fault)
  );

  always_comb begin
    state_nx = state;
    accept   = start && (state != WAIT);
    case (state)
      IDLE, DONE, ERR: state_nx = IDLE;
      WAIT:            if (cnt == '0) state_nx = DONE;
      default:         state_nx = IDLE;
    endcase
    if (accept) state_nx = (!sel_ok || fault) ? ERR : WAIT;
    busy   = (state == WAIT);
    done   = (state == DONE);
    mem_wr = busy && wr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      wr_q     <= 1'b0;
      misalign <= 1'b0;
      bad_sel  <= 1'b0;
    end else begin
      state    <= state_nx;
      misalign <= 1'b0;
      bad_sel  <= 1'b0;
      if (accept) begin
        // Faulting address is kept so the control unit can capture it.
        addr     <= src_sel;
        wr_q     <= write;
        cnt      <= 4'(MEM_LAT);
        bad_sel  <= !sel_ok;
        misalign <= sel_ok && fault;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_iord_addr_unit.sv
// Three differently parameterised units share one stimulus stream and are checked against a busy-countdown model.
module tb_iord_addr_unit;

  localparam int NI = 3;
  localparam int NS [NI] = '{4, 3, 4};
  localparam int LT [NI] = '{1, 0, 3};

  logic         clk = 1'b0;
  logic         reset, start, write;
  logic [1:0]   sel, size;
  logic [31:0]  src [4];
  logic [127:0] src_flat;

  logic [31:0] o_addr [NI];
  logic        o_wr [NI], o_busy [NI], o_done [NI], o_mis [NI], o_bad [NI];

  int          m_left [NI];
  logic [31:0] m_addr [NI];
  bit          m_wr [NI], m_done [NI], m_mis [NI], m_bad [NI];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign src_flat = {src[3], src[2], src[1], src[0]};

  iord_addr_unit #(.WIDTH(32), .NSRC(4), .MEM_LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .src_flat(src_flat),
    .size(size), .write(write), .addr(o_addr[0]), .mem_wr(o_wr[0]), .busy(o_busy[0]),
    .done(o_done[0]), .misalign(o_mis[0]), .bad_sel(o_bad[0]));

  iord_addr_unit #(.WIDTH(32), .NSRC(3), .MEM_LAT(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .src_flat(src_flat[95:0]),
    .size(size), .write(write), .addr(o_addr[1]), .mem_wr(o_wr[1]), .busy(o_busy[1]),
    .done(o_done[1]), .misalign(o_mis[1]), .bad_sel(o_bad[1]));

  iord_addr_unit #(.WIDTH(32), .NSRC(4), .MEM_LAT(3)) u_c (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .src_flat(src_flat),
    .size(size), .write(write), .addr(o_addr[2]), .mem_wr(o_wr[2]), .busy(o_busy[2]),
    .done(o_done[2]), .misalign(o_mis[2]), .bad_sel(o_bad[2]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic bit misaligned(logic [31:0] a, logic [1:0] sz);
    case (sz)
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // An accepted good access keeps the unit busy for MEM_LAT+1 cycles; done marks the cycle it drains.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      bit free;
      free      = (m_left[i] == 0);
      m_done[i] = (m_left[i] == 1);
      m_mis[i]  = 1'b0;
      m_bad[i]  = 1'b0;
      if (m_left[i] > 0) m_left[i]--;
      if (reset) begin
        m_left[i] = 0; m_addr[i] = '0; m_wr[i] = 1'b0; m_done[i] = 1'b0;
      end else if (free && start) begin
        if (int'(sel) >= NS[i]) begin
          m_bad[i]  = 1'b1;
          m_addr[i] = '0;
        end else begin
          m_addr[i] = src[sel];
          if (misaligned(src[sel], size)) m_mis[i] = 1'b1;
          else begin
            m_left[i] = LT[i] + 1;
            m_wr[i]   = write;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("addr%0d", i),     o_addr[i],      m_addr[i]);
      chk($sformatf("busy%0d", i),     32'(o_busy[i]), 32'(m_left[i] > 0));
      chk($sformatf("mem_wr%0d", i),   32'(o_wr[i]),   32'(m_left[i] > 0 && m_wr[i]));
      chk($sformatf("done%0d", i),     32'(o_done[i]), 32'(m_done[i]));
      chk($sformatf("misalign%0d", i), 32'(o_mis[i]),  32'(m_mis[i]));
      chk($sformatf("bad_sel%0d", i),  32'(o_bad[i]),  32'(m_bad[i]));
    end
  endtask

  task automatic drive(bit r, bit st, logic [1:0] s, logic [1:0] sz, bit w, int n);
    reset = r; start = st; sel = s; size = sz; write = w;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_left[i] = 0; m_addr[i] = '0; m_wr[i] = 1'b0;
      m_done[i] = 1'b0; m_mis[i] = 1'b0; m_bad[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) src[i] = 32'h100 * (i + 1);
    drive(1, 0, 0, 2'b10, 0, 2);

    // reset one cycle into a store access
    src[1] = 32'h0000_0200;
    drive(0, 1, 1, 2'b10, 1, 1);
    drive(1, 0, 1, 2'b10, 1, 1);
    drive(0, 0, 1, 2'b10, 1, 6);

    // PC word load
    src[0] = 32'h0000_0040;
    drive(0, 1, 0, 2'b10, 0, 1);
    drive(0, 0, 0, 2'b10, 0, 6);

    // AluOut halfword store
    src[1] = 32'h1000_0006;
    drive(0, 1, 1, 2'b01, 1, 1);
    drive(0, 0, 1, 2'b01, 1, 6);

    // misaligned word
    src[1] = 32'h0000_0102;
    drive(0, 1, 1, 2'b10, 0, 1);
    drive(0, 0, 1, 2'b10, 0, 3);

    // select 3: invalid only for the 3-source unit; then reserved size
    src[3] = 32'h0000_0300;
    drive(0, 1, 3, 2'b10, 0, 1);
    drive(0, 0, 3, 2'b10, 0, 6);
    drive(0, 1, 0, 2'b11, 0, 1);
    drive(0, 0, 0, 2'b11, 0, 3);

    // start held high with sel/sources churning under the busy units
    src[0] = 32'h0000_0080;
    for (int k = 0; k < 10; k++) begin
      src[1] = $urandom & 32'hFFFF_FFFC;
      drive(0, 1, 2'($urandom_range(0, 1)), 2'b10, 1, 1);
    end
    drive(0, 0, 0, 2'b10, 0, 5);

    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 4; i++)
        src[i] = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) != 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
